avalon_mm_cmd_master: RTL
=========================

Name: avalon_mm_cmd_master

Overview:
Avalon-MM master that issues single-word read/write transfers to memory-mapped slaves, such as the actuator PIO and LED output slaves, on behalf of a local command source (control FSM or test sequencer).
- Accepts one command at a time over a valid/ready handshake.
- Drives the Avalon-MM master signals and honours waitrequest.
- Returns read data or a timeout error on a response handshake.

Parameters:
ADDR_W, 2, Avalon address width in words
DATA_W, 32, data width
TIMEOUT, 255, max waitrequest cycles per transfer before abort (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  master can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target word address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data (0 for writes and errors)
rsp_error  out  1  transfer aborted by timeout
avm_address  out  ADDR_W  Avalon address
avm_read  out  1  Avalon read strobe
avm_write  out  1  Avalon write strobe
avm_writedata  out  DATA_W  Avalon write data
avm_readdata  in  DATA_W  Avalon read data
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (async, active-high): state IDLE. All outputs are 0 (avm_*, rsp_*, cmd_ready), except cmd_ready, which is 1 in the first clock after reset release. Wait counter is 0.
- States: IDLE, XFER, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register addr/wdata/write, go to XFER next cycle, cmd_ready=0.
- XFER:
  - avm_address/avm_writedata are held from the registers.
  - avm_write=cmd_write and avm_read=~cmd_write, both registered outputs. Exactly one is high.
  - The transfer completes on the first rising edge where avm_waitrequest=0 with the strobe high.
    - On that edge, for a read, capture avm_readdata into rsp_rdata.
    - For a write, set rsp_rdata=0.
    - rsp_error=0; the strobe drops next cycle; go to RESP.
  - Wait counter increments each cycle avm_waitrequest=1.
    - If the counter reaches TIMEOUT while waitrequest is still 1, drop the strobe, set rsp_error=1 and rsp_rdata=0, and go to RESP.
- Timing:
  - Zero-wait slave: strobe high for exactly 1 cycle.
  - Command accept to rsp_valid = 2 cycles minimum.
  - With N waitrequest cycles (N<TIMEOUT): strobe width N+1, latency N+2.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_error stable until rsp_valid&rsp_ready.
  - Then go to IDLE, clear the counter, rsp_valid=0.
  - No new command is accepted while in RESP (cmd_ready=0).
- Avalon address/data/strobes do not change while avm_waitrequest=1.
- cmd_valid during XFER/RESP is ignored (cmd_ready=0). The source must hold the command until accepted.
- Reset mid-transfer: the strobe drops immediately (asynchronous) and any pending response is discarded.
- TIMEOUT counter width is clog2(TIMEOUT+1). The counter never wraps; it saturates at the abort point.

Decomposition:
- Shared package avalon_pkg:
  - state enum (ST_IDLE, ST_XFER, ST_RESP)
  - default ADDR_W/DATA_W constants
  - PIO register offset constants (DATA=0)
- One natural sub-module, avalon_wait_timer: load/clear, increment-on-enable, expired flag. Reusable by other masters.
- Everything else stays in one FSM module.

Test Plan:
1. Write, zero-wait slave: cmd write addr=0 data=0x1 -> avm_write high 1 cycle with address=0, writedata=0x1. rsp_valid 2 cycles after accept, rsp_error=0, rsp_rdata=0. Slave output toggles to 1.
2. Read, zero-wait: the slave holds 0x1 at addr 0; cmd read addr=0 -> avm_read 1 cycle, rsp_rdata=0x00000001, rsp_error=0. A read of addr=1 returns 0.
3. Waitrequest 3 cycles on write addr=2 data=0xA5A5A5A5 -> strobe high 4 cycles, address/writedata stable throughout, rsp_valid at accept+5.
4. Timeout: TIMEOUT=4, waitrequest stuck high -> strobe drops after 4 stall cycles, rsp_error=1, rsp_rdata=0. The next command is accepted normally after the response handshake.
5. Back-pressure: rsp_ready held low 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, a second cmd_valid is not accepted. It is accepted in IDLE right after rsp_ready goes high.
6. Reset during XFER with waitrequest=1 -> avm_read/avm_write fall without waiting for a clock edge. After release: IDLE, cmd_ready=1, rsp_valid=0.

Source files
------------

// File: rtl/avalon_pkg.sv
// avalon_pkg: shared state encoding and default widths for the Avalon-MM command master.
package avalon_pkg;
    localparam int ADDR_W_DEF   = 2;
    localparam int DATA_W_DEF   = 32;
    localparam int PIO_DATA_OFS = 0;
    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_t;
endpackage

// File: rtl/avalon_wait_timer.sv
// avalon_wait_timer: saturating stall counter with clear, enable and limit flags.
module avalon_wait_timer #(
    parameter  int LIMIT = 255,
    localparam int CW    = $clog2(LIMIT + 1)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last,
    output logic o_expired
);
    logic [CW-1:0] r_count;
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) r_count <= '0;
        else if (i_clear) r_count <= '0;
        else if (i_en && !o_expired) r_count <= r_count + 1'b1;
    // o_last means the next enabled cycle reaches the limit
    assign o_last    = (r_count == CW'(LIMIT - 1));
    assign o_expired = (r_count == CW'(LIMIT));
endmodule

// File: rtl/avalon_mm_cmd_master.sv
// avalon_mm_cmd_master: single-word Avalon-MM read/write master driven by a valid/ready
// command port, returning read data or a waitrequest timeout on a response port.
module avalon_mm_cmd_master
    import avalon_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [DATA_W-1:0] i_cmd_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_read,
    output logic              o_avm_write,
    output logic [DATA_W-1:0] o_avm_writedata,
    input  logic [DATA_W-1:0] i_avm_readdata,
    input  logic              i_avm_waitrequest
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_read;
    logic              r_write;
    logic              r_rsp_valid;
    logic              r_rsp_error;
    logic              w_stall;
    logic              w_done;
    logic              w_abort;
    logic              w_last;
    logic              w_expired;
    assign w_stall = (r_state == ST_XFER) && i_avm_waitrequest;
    assign w_done  = (r_state == ST_XFER) && !i_avm_waitrequest;
    assign w_abort = w_stall && (w_last || w_expired);
    avalon_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (r_state == ST_IDLE),
        .i_en      (w_stall),
        .o_last    (w_last),
        .o_expired (w_expired)
    );
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_cmd_valid) begin
                    r_addr  <= i_cmd_addr;
                    r_wdata <= i_cmd_wdata;
                    r_write <= i_cmd_write;
                    r_read  <= !i_cmd_write;
                    r_state <= ST_XFER;
                end
                ST_XFER: if (w_done || w_abort) begin
                    r_read      <= 1'b0;
                    r_write     <= 1'b0;
                    r_rdata     <= (w_done && r_read) ? i_avm_readdata : '0;
                    r_rsp_error <= !w_done;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: if (i_rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    // ready is gated by reset so it reads 0 while reset is held and 1 right after release
    assign o_cmd_ready     = (r_state == ST_IDLE) && !i_reset;
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_rdata     = r_rdata;
    assign o_rsp_error     = r_rsp_error;
    assign o_avm_address   = r_addr;
    assign o_avm_read      = r_read;
    assign o_avm_write     = r_write;
    assign o_avm_writedata = r_wdata;
endmodule
